regfile: RTL

- General-purpose register file: the receiving end of the write-back bus that the MEM stage drives (`wd`/`wreg`/`wdata`, registered through MEM/WB).
- 32 x 32-bit registers.
- One synchronous write port, driven by WB.
- Two read ports, consumed by ID.
- Internal write-to-read bypass, so ID sees a value written back in the same cycle.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_rdport.sv | 27 ++
 rtl/regfile.sv | 59 +++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register file
package regfile_pkg;
  localparam int REG_NUM      = 32;
  localparam int REG_NUM_LOG2 = 5;
  localparam int REG_WIDTH    = 32;

  typedef logic [REG_NUM_LOG2-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]    reg_word_t;

  localparam logic      RST_ENABLE    = 1'b1;
  localparam logic      WRITE_ENABLE  = 1'b1;
  localparam logic      READ_ENABLE   = 1'b1;
  localparam logic      READ_DISABLE  = 1'b0;
  localparam reg_word_t ZERO_DWORD    = '0;
  localparam reg_addr_t NOP_REG_ADDR  = '0;

  // True when a write-back actually lands in the array (register 0 is hard-wired).
  function automatic logic write_hits(input logic we, input reg_addr_t waddr);
    return (we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR);
  endfunction
endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port with write-back bypass
module regfile_rdport
  import regfile_pkg::*;
(
  input  logic      rst,
  input  logic      re,
  input  reg_addr_t raddr,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_word_t wdata,
  input  reg_word_t word,
  output reg_word_t rdata
);
  always_comb begin
    rdata = ZERO_DWORD;
    if (rst == RST_ENABLE) begin
      rdata = ZERO_DWORD;
    end else if (raddr == NOP_REG_ADDR) begin
      rdata = ZERO_DWORD;
    end else if (re == READ_ENABLE && we == WRITE_ENABLE && waddr == raddr) begin
      // WB-to-ID hazard: hand over the value being written this cycle.
      rdata = wdata;
    end else if (re == READ_ENABLE) begin
      rdata = word;
    end
  end
endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, one write port, two bypassed read ports
module regfile
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [REG_NUM_LOG2-1:0] waddr,
  input  logic [REG_WIDTH-1:0]    wdata,
  input  logic                    re1,
  input  logic [REG_NUM_LOG2-1:0] raddr1,
  output logic [REG_WIDTH-1:0]    rdata1,
  input  logic                    re2,
  input  logic [REG_NUM_LOG2-1:0] raddr2,
  output logic [REG_WIDTH-1:0]    rdata2
);
  reg_word_t regs_q [REG_NUM];
  reg_word_t regs_d [REG_NUM];

  always_comb begin
    regs_d = regs_q;
    if (write_hits(we, waddr)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Reset wins over a colliding write so the entry never captures wdata.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= ZERO_DWORD;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_rdport u_rdport1 (
    .rst   (rst),
    .re    (re1),
    .raddr (raddr1),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .word  (regs_q[raddr1]),
    .rdata (rdata1)
  );

  regfile_rdport u_rdport2 (
    .rst   (rst),
    .re    (re2),
    .raddr (raddr2),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .word  (regs_q[raddr2]),
    .rdata (rdata2)
  );
endmodule
